// File: rtl/cpu_lockstep_checker.sv
// Lockstep checker: captures {PC,A,X,Y} at each instruction boundary of a reference and a DUV CPU,
// buffers each side in its own FIFO and compares the two streams in retirement order.
module cpu_lockstep_checker #(
  parameter int DEPTH        = 8,
  parameter int TIMEOUT      = 1024,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        ref_sync_i,
  input  logic [39:0] ref_snap_i,
  input  logic        duv_sync_i,
  input  logic [39:0] duv_snap_i,
  output logic [31:0] match_cnt_o,
  output logic [15:0] mismatch_cnt_o,
  output logic        fail_o,
  output logic [31:0] first_idx_o,
  output logic [39:0] first_ref_o,
  output logic [39:0] first_duv_o,
  output logic        ovf_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  // Side 0 is the reference CPU, side 1 the DUV.
  logic [1:0][39:0] snap;
  logic [1:0]       sync_in;

  assign snap    = {duv_snap_i, ref_snap_i};
  assign sync_in = {duv_sync_i, ref_sync_i};

  logic [1:0]       state_q, state_d;
  logic [1:0]       sync_q;
  logic [1:0][AW:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][AW:0] rd_ptr_q, rd_ptr_d;
  logic [39:0]      mem_q [2][DEPTH];

  logic [31:0]   match_cnt_q, match_cnt_d;
  logic [15:0]   mismatch_cnt_q, mismatch_cnt_d;
  logic          fail_q, fail_d;
  logic [31:0]   first_idx_q, first_idx_d;
  logic [39:0]   first_ref_q, first_ref_d;
  logic [39:0]   first_duv_q, first_duv_d;
  logic          ovf_q, ovf_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic [1:0][AW:0] level;
  logic [1:0]       empty, full, sync_edge, push, drop;
  logic [39:0]      head_ref, head_duv;
  logic             run_active, flush, compare, mismatch;
  logic [31:0]      cmp_idx;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      level[s] = wr_ptr_q[s] - rd_ptr_q[s];
      empty[s] = (level[s] == '0);
      full[s]  = (level[s] == DEPTH_L);
    end
  end

  assign head_ref = mem_q[0][rd_ptr_q[0][AW-1:0]];
  assign head_duv = mem_q[1][rd_ptr_q[1][AW-1:0]];

  assign run_active = (state_q == ST_RUN) && en_i && !clr_i;
  assign flush      = clr_i || !en_i || (state_q == ST_IDLE);
  assign compare    = run_active && !empty[0] && !empty[1];
  assign mismatch   = compare && (head_ref != head_duv);
  assign cmp_idx    = match_cnt_q + {16'd0, mismatch_cnt_q};
  assign sync_edge  = sync_in & ~sync_q;

  // A full FIFO still accepts a push when the same cycle pops it.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      push[s] = run_active && sync_edge[s] && (!full[s] || compare);
      drop[s] = run_active && sync_edge[s] && full[s] && !compare;
    end
  end

  // NOTE: every always_comb output gets a default on entry so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr_d[s] = wr_ptr_q[s] + PTR_ONE;
        if (compare) rd_ptr_d[s] = rd_ptr_q[s] + PTR_ONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = en_i ? ST_RUN : ST_IDLE;
    end else if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  if (mismatch && STOP_ON_FAIL) state_d = ST_FAIL;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    fail_d         = fail_q;
    first_idx_d    = first_idx_q;
    first_ref_d    = first_ref_q;
    first_duv_d    = first_duv_q;
    ovf_d          = ovf_q;
    if (clr_i) begin
      match_cnt_d    = '0;
      mismatch_cnt_d = '0;
      fail_d         = 1'b0;
      first_idx_d    = '0;
      first_ref_d    = '0;
      first_duv_d    = '0;
      ovf_d          = 1'b0;
    end else begin
      if (compare && !mismatch) match_cnt_d = match_cnt_q + 32'd1;
      if (mismatch) begin
        if (mismatch_cnt_q != 16'hFFFF) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
        if (!fail_q) begin
          fail_d      = 1'b1;
          first_idx_d = cmp_idx;
          first_ref_d = head_ref;
          first_duv_d = head_duv;
        end
      end
      if (|drop) ovf_d = 1'b1;
    end
  end

  // The timeout counter only runs while one side holds data and the other has nothing to match it.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (flush) begin
      to_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (compare || (empty[0] && empty[1])) begin
        to_cnt_d = '0;
      end else if (empty[0] != empty[1]) begin
        if (to_cnt_q != TIMEOUT_L) to_cnt_d = to_cnt_q + TO_ONE;
      end
    end
    if (clr_i) begin
      timeout_d = 1'b0;
    end else if (to_cnt_d == TIMEOUT_L) begin
      timeout_d = 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sync_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      fail_q         <= 1'b0;
      first_idx_q    <= '0;
      first_ref_q    <= '0;
      first_duv_q    <= '0;
      ovf_q          <= 1'b0;
      timeout_q      <= 1'b0;
      to_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_in;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      fail_q         <= fail_d;
      first_idx_q    <= first_idx_d;
      first_ref_q    <= first_ref_d;
      first_duv_q    <= first_duv_d;
      ovf_q          <= ovf_d;
      timeout_q      <= timeout_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s][AW-1:0]] <= snap[s];
    end
  end

  assign match_cnt_o    = match_cnt_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign fail_o         = fail_q;
  assign first_idx_o    = first_idx_q;
  assign first_ref_o    = first_ref_q;
  assign first_duv_o    = first_duv_q;
  assign ovf_o          = ovf_q;
  assign timeout_o      = timeout_q;
  assign busy_o         = !(empty[0] && empty[1]);

endmodule

// File: tb/tb_cpu_lockstep_checker.sv
// Self-checking bench for cpu_lockstep_checker: directed scenarios with randomized snapshots,
// checked every cycle against a queue-based model of the retirement-order comparison.
module tb_cpu_lockstep_checker;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 1024;
  localparam int NCYC    = 64;

  logic        clk = 1'b0;
  logic        rst_n, en_i, clr_i;
  logic        ref_sync_i, duv_sync_i;
  logic [39:0] ref_snap_i, duv_snap_i;
  logic [31:0] match_cnt_o, first_idx_o;
  logic [15:0] mismatch_cnt_o;
  logic        fail_o, ovf_o, timeout_o, busy_o;
  logic [39:0] first_ref_o, first_duv_o;

  cpu_lockstep_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_FAIL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i),
    .ref_sync_i(ref_sync_i), .ref_snap_i(ref_snap_i),
    .duv_sync_i(duv_sync_i), .duv_snap_i(duv_snap_i),
    .match_cnt_o(match_cnt_o), .mismatch_cnt_o(mismatch_cnt_o), .fail_o(fail_o),
    .first_idx_o(first_idx_o), .first_ref_o(first_ref_o), .first_duv_o(first_duv_o),
    .ovf_o(ovf_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: one snapshot queue per CPU plus the observable counters and flags.
  typedef enum {M_IDLE, M_RUN, M_FROZEN} mode_e;
  mode_e       m_mode;
  logic [39:0] rq[$];
  logic [39:0] dq[$];
  logic [31:0] m_match, m_idx;
  logic [15:0] m_mis;
  logic [39:0] m_ref, m_duv;
  logic        m_fail, m_ovf, m_to, m_prev_r, m_prev_d;
  int          m_tocnt;

  // Per-cycle stimulus schedule, side 0 = ref, side 1 = DUV.
  logic        sync_at [2][NCYC];
  logic [39:0] snap_at [2][NCYC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    dq.delete();
    m_match = '0; m_mis = '0; m_idx = '0; m_ref = '0; m_duv = '0;
    m_fail = 1'b0; m_ovf = 1'b0; m_to = 1'b0; m_tocnt = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_mode   = M_IDLE;
    m_prev_r = 1'b0;
    m_prev_d = 1'b0;
  endtask

  task automatic model_step();
    int nr, nd;
    bit cmp, er, ed;
    logic [39:0] h0, h1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    er = ref_sync_i && !m_prev_r;
    ed = duv_sync_i && !m_prev_d;
    m_prev_r = ref_sync_i;
    m_prev_d = duv_sync_i;
    if (clr_i) begin
      model_clear();
      m_mode = en_i ? M_RUN : M_IDLE;
    end else if (!en_i) begin
      m_mode = M_IDLE;
      rq.delete();
      dq.delete();
      m_tocnt = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      nr  = rq.size();
      nd  = dq.size();
      cmp = (nr > 0) && (nd > 0);
      if (cmp) begin
        h0 = rq.pop_front();
        h1 = dq.pop_front();
        if (h0 == h1) begin
          m_match = m_match + 1;
        end else begin
          if (!m_fail) begin
            m_fail = 1'b1;
            m_idx  = m_match + 32'(m_mis);
            m_ref  = h0;
            m_duv  = h1;
          end
          if (m_mis != 16'hFFFF) m_mis = m_mis + 1;
          m_mode = M_FROZEN;
        end
      end
      if (cmp || (nr == 0 && nd == 0)) m_tocnt = 0;
      else if (m_tocnt < TIMEOUT) m_tocnt++;
      if (m_tocnt == TIMEOUT) m_to = 1'b1;
      if (er) begin
        if (nr < DEPTH || cmp) rq.push_back(ref_snap_i);
        else m_ovf = 1'b1;
      end
      if (ed) begin
        if (nd < DEPTH || cmp) dq.push_back(duv_snap_i);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("match_cnt", 64'(match_cnt_o), 64'(m_match));
    check("mismatch_cnt", 64'(mismatch_cnt_o), 64'(m_mis));
    check("fail", 64'(fail_o), 64'(m_fail));
    check("first_idx", 64'(first_idx_o), 64'(m_idx));
    check("first_ref", 64'(first_ref_o), 64'(m_ref));
    check("first_duv", 64'(first_duv_o), 64'(m_duv));
    check("ovf", 64'(ovf_o), 64'(m_ovf));
    check("timeout", 64'(timeout_o), 64'(m_to));
    check("busy", 64'(busy_o), 64'(rq.size() != 0 || dq.size() != 0));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_sched();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < NCYC; c++) begin
        sync_at[s][c] = 1'b0;
        snap_at[s][c] = '0;
      end
  endtask

  task automatic add_ev(input int side, input int cyc, input logic [39:0] v);
    sync_at[side][cyc] = 1'b1;
    snap_at[side][cyc] = v;
  endtask

  function automatic logic [39:0] rnd40();
    return {8'($urandom()), $urandom()};
  endfunction

  task automatic play(input int from, input int to);
    for (int c = from; c < to; c++) begin
      ref_sync_i = sync_at[0][c];
      duv_sync_i = sync_at[1][c];
      ref_snap_i = sync_at[0][c] ? snap_at[0][c] : rnd40();
      duv_snap_i = sync_at[1][c] ? snap_at[1][c] : rnd40();
      tick();
    end
    ref_sync_i = 1'b0;
    duv_sync_i = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_match"}, 64'(match_cnt_o), 64'd0);
    check({tag, "_mis"}, 64'(mismatch_cnt_o), 64'd0);
    check({tag, "_fail"}, 64'(fail_o), 64'd0);
    check({tag, "_idx"}, 64'(first_idx_o), 64'd0);
    check({tag, "_ovf"}, 64'(ovf_o), 64'd0);
    check({tag, "_to"}, 64'(timeout_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Two matching pairs followed by four unanswered ref snapshots.
  task automatic queue_four();
    clear_sched();
    for (int i = 0; i < 2; i++) begin
      logic [39:0] v;
      v = rnd40();
      add_ev(0, 2 * i, v);
      add_ev(1, 2 * i + 1, v);
    end
    for (int i = 0; i < 4; i++) add_ev(0, 6 + 2 * i, rnd40());
    play(0, 16);
    check("q4_busy", 64'(busy_o), 64'd1);
    check("q4_match", 64'(match_cnt_o), 64'd2);
  endtask

  // One side fills its FIFO, then the other side's pushes trigger compares that coincide with
  // further pushes into the full FIFO.
  task automatic full_pair(input int a);
    logic [39:0] v [12];
    int b;
    b = 1 - a;
    for (int i = 0; i < 12; i++) v[i] = rnd40();
    clear_sched();
    for (int i = 0; i < 8; i++) add_ev(a, 2 * i, v[i]);
    for (int i = 0; i < 4; i++) begin
      add_ev(b, 16 + 2 * i, v[i]);
      add_ev(a, 17 + 2 * i, v[8 + i]);
    end
    for (int i = 4; i < 12; i++) add_ev(b, 24 + 2 * (i - 4), v[i]);
    play(0, 44);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] v, vr, vd;
    int t;

    rst_n = 1'b0; en_i = 1'b0; clr_i = 1'b0;
    ref_sync_i = 1'b0; duv_sync_i = 1'b0;
    ref_snap_i = '0; duv_snap_i = '0;
    model_reset();
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    en_i  = 1'b1;
    tick();

    // 1: identical streams, DUV three cycles behind
    clear_sched();
    t = 0;
    for (int i = 0; i < 5; i++) begin
      v = rnd40();
      add_ev(0, t, v);
      add_ev(1, t + 3, v);
      t += 2 + int'($urandom_range(0, 2));
    end
    play(0, t + 8);
    check("t1_match", 64'(match_cnt_o), 64'd5);
    check("t1_mis", 64'(mismatch_cnt_o), 64'd0);
    check("t1_busy", 64'(busy_o), 64'd0);

    // 2: third snapshot differs, checking freezes
    pulse_clr();
    clear_sched();
    for (int i = 0; i < 5; i++) begin
      v  = rnd40();
      vr = v;
      vd = v;
      if (i == 2) begin
        vr[23:16] = 8'h41; vr[15:8] = 8'h41;
        vd[23:16] = 8'h42; vd[15:8] = 8'h42;
      end
      add_ev(0, 3 * i, vr);
      add_ev(1, 3 * i + 1, vd);
    end
    play(0, 20);
    check("t2_fail", 64'(fail_o), 64'd1);
    check("t2_idx", 64'(first_idx_o), 64'd2);
    check("t2_ref_byte", 64'(first_ref_o[15:8]), 64'h41);
    check("t2_duv_byte", 64'(first_duv_o[15:8]), 64'h42);
    check("t2_match", 64'(match_cnt_o), 64'd2);
    clear_sched();
    for (int i = 0; i < 3; i++) begin
      v = rnd40();
      add_ev(0, 2 * i, v);
      add_ev(1, 2 * i + 1, v);
    end
    play(0, 10);
    check("t2_frozen_match", 64'(match_cnt_o), 64'd2);
    check("t2_frozen_mis", 64'(mismatch_cnt_o), 64'd1);

    // 3: ref runs away, DUV silent
    pulse_clr();
    clear_sched();
    for (int i = 0; i <= DEPTH; i++) add_ev(0, 2 * i, rnd40());
    play(0, 2 * DEPTH);
    check("t3_no_ovf_yet", 64'(ovf_o), 64'd0);
    play(2 * DEPTH, 2 * DEPTH + 1);
    check("t3_ovf", 64'(ovf_o), 64'd1);
    for (int k = 2 * DEPTH + 1; k < TIMEOUT; k++) tick();
    check("t3_no_timeout_yet", 64'(timeout_o), 64'd0);
    tick();
    check("t3_timeout", 64'(timeout_o), 64'd1);

    // 4: sync held high for ten cycles gives one push
    pulse_clr();
    clear_sched();
    for (int c = 0; c < 10; c++) add_ev(0, c, rnd40());
    add_ev(1, 12, snap_at[0][0]);
    play(0, 16);
    check("t4_match", 64'(match_cnt_o), 64'd1);
    check("t4_mis", 64'(mismatch_cnt_o), 64'd0);

    // 5: pushes into a full FIFO alongside compare-pops, either side
    pulse_clr();
    full_pair(0);
    full_pair(1);
    check("t5_ovf", 64'(ovf_o), 64'd0);
    check("t5_match", 64'(match_cnt_o), 64'd24);
    check("t5_mis", 64'(mismatch_cnt_o), 64'd0);
    check("t5_busy", 64'(busy_o), 64'd0);

    // 6: asynchronous reset, then synchronous clear, with entries queued
    pulse_clr();
    queue_four();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("t6_rst");
    tick();
    rst_n = 1'b1;
    tick();
    queue_four();
    pulse_clr();
    check_zero("t6_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
